// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding and
// default statistics counter width.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEF = 32;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALT   = 2'd1;
  localparam logic [1:0] ST_RESUME = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_stat_cnt.sv
// Single wrapping statistics counter with synchronous clear and increment.
module pipe_stat_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Counter register; clear wins over increment, wraps silently.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer and halt/resume FSM for the 5-stage pipeline.
// Statistics counters are built only when PIPE_STATS_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             mem_wait,
  input  logic             halt_req,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0] state_r;
  logic [1:0] next_state_s;
  logic [1:0] eff_state_s;
  logic       go_q_r;
  logic       go_rise_s;
  logic       halt_take_s;

  // While rst is high the outputs decode as if already in RUN.
  assign eff_state_s = rst ? ST_RUN : state_r;
  assign go_rise_s   = go & ~go_q_r;
  // Only RUN honours halt_req; in RESUME the same syscall is still retiring.
  assign halt_take_s = (eff_state_s == ST_RUN) & halt_req;
  assign halted      = (eff_state_s == ST_HALT);

  // Per-stage enable/flush decode and next-state selection.
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    next_state_s = ST_RUN;
    case (eff_state_s)
      ST_RUN, ST_RESUME: begin
        if (halt_take_s) begin
          next_state_s = ST_HALT;
        end else if (mem_wait) begin
          next_state_s = ST_RUN;
        end else if (branch_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
      ST_HALT: begin
        if (go_rise_s) begin
          next_state_s = ST_RESUME;
        end else begin
          next_state_s = ST_HALT;
        end
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // FSM state and go edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      go_q_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      go_q_r  <= go;
    end
  end

`ifdef PIPE_STATS_EN
  logic cycle_inc_s;
  logic bubble_inc_s;
  logic flush_inc_s;

  // A branch flush drives both flushes; a lone idex_flush is an issued bubble.
  assign cycle_inc_s  = (eff_state_s != ST_HALT);
  assign flush_inc_s  = ifid_flush;
  assign bubble_inc_s = idex_flush & ~ifid_flush;

  pipe_stat_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .clr (rst),
    .inc (cycle_inc_s),
    .cnt (cycle_cnt)
  );

  pipe_stat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .clr (rst),
    .inc (bubble_inc_s),
    .cnt (bubble_cnt)
  );

  pipe_stat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (flush_inc_s),
    .cnt (flush_cnt)
  );
`else
  assign cycle_cnt  = {CNT_W{1'b0}};
  assign bubble_cnt = {CNT_W{1'b0}};
  assign flush_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl; expected records are queued
// when a vector is driven and compared mid-cycle.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 32;
`ifdef PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [5:0]  in;   // {rst, load_use, branch_taken, mem_wait, halt_req, go}
    logic [4:0]  en;   // {pc, ifid, idex, exmem, memwb}
    logic [1:0]  fl;   // {ifid_flush, idex_flush}
    logic        hl;
    logic        chk_cnt;
    int unsigned c;
    int unsigned b;
    int unsigned f;
  } vec_t;

  logic clk = 1'b0;
  logic rst, load_use, branch_taken, mem_wait, halt_req, go;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, halted;
  logic [CNT_W-1:0] cycle_cnt, bubble_cnt, flush_cnt;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .mem_wait     (mem_wait),
    .halt_req     (halt_req),
    .go           (go),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt),
    .bubble_cnt   (bubble_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic add(input logic [5:0] in, input logic [4:0] en, input logic [1:0] fl,
                     input logic hl, input logic chk, input int unsigned c,
                     input int unsigned b, input int unsigned f);
    vec_t v;
    v.in = in; v.en = en; v.fl = fl; v.hl = hl; v.chk_cnt = chk;
    v.c = c; v.b = b; v.f = f;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // in(rst lu br mw hr go)  en       fl     hl  chk  c   b  f
    add(6'b100000, 5'b11111, 2'b00, 1'b0, 1'b0,  0, 0, 0); // reset, idle
    add(6'b110000, 5'b00111, 2'b01, 1'b0, 1'b1,  0, 0, 0); // reset, RUN decode
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1,  0, 0, 0);
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1,  1, 0, 0);
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1,  2, 0, 0);
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1,  3, 0, 0);
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1,  4, 0, 0);
    add(6'b010000, 5'b00111, 2'b01, 1'b0, 1'b1,  5, 0, 0); // load-use bubble
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1,  6, 1, 0);
    add(6'b011000, 5'b11111, 2'b11, 1'b0, 1'b1,  7, 1, 0); // branch beats load-use
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1,  8, 1, 1);
    add(6'b010100, 5'b00000, 2'b00, 1'b0, 1'b1,  9, 1, 1); // mem_wait x3
    add(6'b010100, 5'b00000, 2'b00, 1'b0, 1'b1, 10, 1, 1);
    add(6'b010100, 5'b00000, 2'b00, 1'b0, 1'b1, 11, 1, 1);
    add(6'b010000, 5'b00111, 2'b01, 1'b0, 1'b1, 12, 1, 1); // deferred load-use
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1, 13, 2, 1);
    add(6'b001100, 5'b00000, 2'b00, 1'b0, 1'b1, 14, 2, 1); // mem_wait hides branch
    add(6'b001000, 5'b11111, 2'b11, 1'b0, 1'b1, 15, 2, 1);
    add(6'b010010, 5'b00000, 2'b00, 1'b0, 1'b1, 16, 2, 2); // halt beats load-use
    add(6'b000010, 5'b00000, 2'b00, 1'b1, 1'b1, 17, 2, 2); // HALT
    add(6'b011110, 5'b00000, 2'b00, 1'b1, 1'b1, 17, 2, 2);
    add(6'b000011, 5'b00000, 2'b00, 1'b1, 1'b1, 17, 2, 2); // go rises
    add(6'b000011, 5'b11111, 2'b00, 1'b0, 1'b1, 17, 2, 2); // RESUME masks halt_req
    add(6'b000001, 5'b11111, 2'b00, 1'b0, 1'b1, 18, 2, 2);
    add(6'b000001, 5'b11111, 2'b00, 1'b0, 1'b1, 19, 2, 2);
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1, 20, 2, 2);
    add(6'b000001, 5'b11111, 2'b00, 1'b0, 1'b1, 21, 2, 2); // go edge in RUN ignored
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1, 22, 2, 2);
    add(6'b000010, 5'b00000, 2'b00, 1'b0, 1'b1, 23, 2, 2);
    add(6'b000001, 5'b00000, 2'b00, 1'b1, 1'b1, 24, 2, 2);
    add(6'b010011, 5'b00111, 2'b01, 1'b0, 1'b1, 24, 2, 2); // RESUME with load-use
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1, 25, 3, 2);
    add(6'b000011, 5'b00000, 2'b00, 1'b0, 1'b1, 26, 3, 2); // halt with go already high
    add(6'b000001, 5'b00000, 2'b00, 1'b1, 1'b1, 27, 3, 2); // held go: no edge
    add(6'b000001, 5'b00000, 2'b00, 1'b1, 1'b1, 27, 3, 2);
    add(6'b000000, 5'b00000, 2'b00, 1'b1, 1'b1, 27, 3, 2);
    add(6'b000001, 5'b00000, 2'b00, 1'b1, 1'b1, 27, 3, 2);
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1, 27, 3, 2); // RESUME
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1, 28, 3, 2);
    add(6'b000010, 5'b00000, 2'b00, 1'b0, 1'b1, 29, 3, 2);
    add(6'b100000, 5'b11111, 2'b00, 1'b0, 1'b1, 30, 3, 2); // rst during HALT
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1,  0, 0, 0);
    add(6'b000000, 5'b11111, 2'b00, 1'b0, 1'b1,  1, 0, 0);
    add(6'b000010, 5'b00000, 2'b00, 1'b0, 1'b1,  2, 0, 0);
    add(6'b000000, 5'b00000, 2'b00, 1'b1, 1'b1,  3, 0, 0);

    {rst, load_use, branch_taken, mem_wait, halt_req, go} = 6'b100000;
    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      vec_t e;
      v = tbl[i];
      {rst, load_use, branch_taken, mem_wait, halt_req, go} = v.in;
      exp_q.push_back(v);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", i);
      end else begin
        e = exp_q.pop_front();
        chk("enables", i, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, e.en});
        chk("flushes", i, {30'd0, ifid_flush, idex_flush}, {30'd0, e.fl});
        chk("halted", i, {31'd0, halted}, {31'd0, e.hl});
        if (e.chk_cnt) begin
          chk("cycle_cnt", i, cycle_cnt, STATS ? e.c : 32'd0);
          chk("bubble_cnt", i, bubble_cnt, STATS ? e.b : 32'd0);
          chk("flush_cnt", i, flush_cnt, STATS ? e.f : 32'd0);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
